pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have clk  input  1  pipeline clock, rising edge active.
REQ-002 SHALL have reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have id_rs, id_rt  input  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have ex_memread  input  1  and ex_rt  input  5: load-in-EX flag and its destination register.
REQ-005 SHALL have ex_branch_taken  input  1  branch resolved taken in EX.
REQ-006 SHALL have id_jump  input  1  jump decoded in ID.
REQ-007 SHALL have mem_busy  input  1  data memory not ready, level.
REQ-008 SHALL have irq  input  1  external interrupt request, level; irq_en  input  1  global interrupt enable.
REQ-009 SHALL have pc_write, ifid_write  output  1 each  PC and IF/ID register write enables.
REQ-010 SHALL have ifid_flush, idex_flush  output  1 each  bubble insertion into IF/ID and ID/EX.
REQ-011 SHALL have pipe_freeze  output  1  hold for ID/EX, EX/MEM and MEM/WB.
REQ-012 SHALL have pc_sel_vec  output  1  select interrupt vector as next PC; irq_ack  output  1  one-cycle acknowledge.
REQ-013 SHALL have stall_cnt  output  16  stall-cycle counter (present only per REQ-030).

Function
REQ-014 SHALL implement states RUN, DRAIN, VECTOR in a registered state register; all other outputs are combinational from state and inputs.
REQ-015 RUN idle outputs SHALL be pc_write=1, ifid_write=1, all flushes 0, pipe_freeze=0, pc_sel_vec=0, irq_ack=0.
REQ-016 Freeze, any state: mem_busy=1 SHALL force pc_write=0, ifid_write=0, pipe_freeze=1, all flushes 0, and SHALL hold state, drain counter and irq latch unchanged.
REQ-017 Load-use in RUN: ex_memread=1, ex_rt!=0 and (ex_rt==id_rs or ex_rt==id_rt) SHALL give pc_write=0, ifid_write=0, idex_flush=1 in the same cycle (one bubble).
REQ-018 Taken branch in RUN SHALL give ifid_flush=1 and idex_flush=1 with pc_write=1, overriding load-use and jump.
REQ-019 Jump in RUN without a taken branch or load-use SHALL give ifid_flush=1 only.
REQ-020 Priority SHALL be mem_busy > interrupt entry > branch > load-use > jump.
REQ-021 Interrupt entry SHALL occur when state=RUN, irq=1, irq_en=1, armed=1 and mem_busy=0; in that cycle ifid_flush=1, idex_flush=1, pc_write=0; next state DRAIN, drain counter loaded with 1.
REQ-022 DRAIN SHALL assert ifid_flush=1, idex_flush=1, pc_write=0, ignore hazard inputs, and decrement the counter each unfrozen cycle; at counter 0 go to VECTOR.
REQ-023 VECTOR SHALL last one unfrozen cycle with pc_sel_vec=1, pc_write=1, irq_ack=1, then return to RUN and clear armed.
REQ-024 armed SHALL set again only after one unfrozen cycle sampling irq=0; a held irq SHALL cause exactly one entry.
REQ-025 irq deasserting during DRAIN SHALL NOT abort the sequence; VECTOR still occurs.
REQ-026 ex_branch_taken during DRAIN or VECTOR SHALL be ignored (entry flushes cover it).

Reset
REQ-027 reset=0 SHALL asynchronously set state=RUN, drain counter=0, armed=1, stall_cnt=0.
REQ-028 During and immediately after reset, outputs SHALL equal RUN idle values (REQ-015) unless inputs create hazards.
REQ-029 Reset asserted mid-DRAIN or mid-VECTOR SHALL abort the sequence with no irq_ack.

Configuration
REQ-030 With HAZARD_PERF_EN defined, stall_cnt SHALL increment by 1 on every clock with pc_write=0 and saturate at 16'hFFFF; without it the stall_cnt port and counter SHALL be absent.

Verification
REQ-031 ex_memread=1, ex_rt=5, id_rs=5 -> same cycle pc_write=0, ifid_write=0, idex_flush=1; ex_rt=0 gives no stall.
REQ-032 ex_branch_taken=1 with load-use condition true -> ifid_flush=1, idex_flush=1, pc_write=1.
REQ-033 irq=1, irq_en=1 held 10 cycles -> flushes for cycles 0-2, pc_sel_vec=irq_ack=1 at cycle 3, single ack only.
REQ-034 mem_busy=1 for 3 cycles during DRAIN -> pipe_freeze=1, VECTOR delayed exactly 3 cycles.
REQ-035 reset pulse during DRAIN -> state RUN, no irq_ack, stall_cnt=0.
REQ-036 HAZARD_PERF_EN: 4 load-use stalls plus 3 freeze cycles -> stall_cnt=7; preload near max -> holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard, flush, freeze and interrupt-entry controller
//
// Purpose: resolves pipeline hazards for a five-stage pipeline. It handles load-use
// stalls, branch and jump flushes, and freezes on a busy data memory. It also
// sequences interrupt entry (RUN -> DRAIN -> VECTOR -> RUN).
// Optional feature macro: HAZARD_PERF_EN adds a saturating 16-bit stall-cycle counter.
//
// Ports:
//   clk              pipeline clock, rising edge
//   reset            asynchronous active-low reset
//   id_rs, id_rt     source registers of the instruction in ID
//   ex_memread       load in EX
//   ex_rt            destination register of the load in EX
//   ex_branch_taken  branch resolved taken in EX
//   id_jump          jump decoded in ID
//   mem_busy         data memory not ready (level)
//   irq, irq_en      interrupt request (level) and global enable
//   pc_write         PC write enable
//   ifid_write       IF/ID write enable
//   ifid_flush       bubble into IF/ID
//   idex_flush       bubble into ID/EX
//   pipe_freeze      hold ID/EX, EX/MEM, MEM/WB
//   pc_sel_vec       select interrupt vector as next PC
//   irq_ack          one-cycle interrupt acknowledge
//   stall_cnt        stall-cycle counter (HAZARD_PERF_EN only)

module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       ex_branch_taken,
  input  logic       id_jump,
  input  logic       mem_busy,
  input  logic       irq,
  input  logic       irq_en,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       pipe_freeze,
  output logic       pc_sel_vec,
  output logic       irq_ack
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [1:0] {RUN, DRAIN, VECTOR} stateT;

  stateT state, stateNext;
  logic  drainCnt, drainCntNext;
  logic  armed, armedNext;
  logic  loadUse;

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign loadUse = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      drainCnt <= 1'b0;
      armed    <= 1'b1;
    end else begin
      state    <= stateNext;
      drainCnt <= drainCntNext;
      armed    <= armedNext;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    pipe_freeze  = 1'b0;
    pc_sel_vec   = 1'b0;
    irq_ack      = 1'b0;
    stateNext    = state;
    drainCntNext = drainCnt;
    armedNext    = armed;

    if (mem_busy) begin
      // Whole pipeline holds; sequencing state is untouched while frozen.
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      pipe_freeze = 1'b1;
    end else begin
      // Re-arming needs a sampled low irq, so a held request enters only once.
      if (!irq) armedNext = 1'b1;
      case (state)
        RUN: begin
          if (irq && irq_en && armed) begin
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            pc_write     = 1'b0;
            stateNext    = DRAIN;
            drainCntNext = 1'b1;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
          end else if (loadUse) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end else if (id_jump) begin
            ifid_flush = 1'b1;
          end
        end
        DRAIN: begin
          // Hazard and branch inputs are ignored: everything younger is being flushed.
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          pc_write   = 1'b0;
          if (drainCnt == 1'b0) stateNext = VECTOR;
          else drainCntNext = drainCnt - 1'b1;
        end
        VECTOR: begin
          pc_sel_vec = 1'b1;
          irq_ack    = 1'b1;
          stateNext  = RUN;
          armedNext  = 1'b0;
        end
        default: stateNext = RUN;
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  logic [15:0] stallCnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stallCnt <= 16'd0;
    else if (!pc_write && (stallCnt != 16'hFFFF)) stallCnt <= stallCnt + 16'd1;
  end

  assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       ex_memread, ex_branch_taken, id_jump, mem_busy, irq, irq_en;
  logic       pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, pc_sel_vec, irq_ack;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, pc_sel_vec, irq_ack}
  localparam logic [6:0] IDLE    = 7'b1100000;
  localparam logic [6:0] FREEZE  = 7'b0000100;
  localparam logic [6:0] FLUSH2  = 7'b0111000;
  localparam logic [6:0] BRANCH  = 7'b1111000;
  localparam logic [6:0] LOADUSE = 7'b0001000;
  localparam logic [6:0] JUMP    = 7'b1110000;
  localparam logic [6:0] VEC     = 7'b1100011;

  logic [6:0] outs;
  assign outs = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, pc_sel_vec, irq_ack};

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .ex_memread(ex_memread),
    .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken), .id_jump(id_jump), .mem_busy(mem_busy),
    .irq(irq), .irq_en(irq_en), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_freeze(pipe_freeze),
    .pc_sel_vec(pc_sel_vec), .irq_ack(irq_ack)
`ifdef HAZARD_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic setIn(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                       input logic [4:0] ert, input logic br, input logic jp,
                       input logic mb, input logic ir, input logic ie);
    id_rs = rs; id_rt = rt; ex_memread = mr; ex_rt = ert; ex_branch_taken = br;
    id_jump = jp; mem_busy = mb; irq = ir; irq_en = ie;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();
  endtask

  task automatic test_reset();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #3;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL reset_during: got %b want %b", outs, IDLE); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nextCycle();
    #4;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL reset_after: got %b want %b", outs, IDLE); end
`ifdef HAZARD_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    nextCycle();
  endtask

  task automatic test_load_use();
    setIn(5, 7, 1, 5, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if (outs !== LOADUSE) begin errors++; $display("FAIL load_use_rs: got %b want %b", outs, LOADUSE); end
    nextCycle();
    setIn(3, 9, 1, 9, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if (outs !== LOADUSE) begin errors++; $display("FAIL load_use_rt: got %b want %b", outs, LOADUSE); end
    nextCycle();
    setIn(0, 0, 1, 0, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL load_use_r0: got %b want %b", outs, IDLE); end
    nextCycle();
    setIn(5, 6, 0, 5, 0, 1, 0, 0, 0);
    #4;
    checks++;
    if (outs !== JUMP) begin errors++; $display("FAIL jump_only: got %b want %b", outs, JUMP); end
    nextCycle();
    setIn(5, 6, 1, 5, 0, 1, 0, 0, 0);
    #4;
    checks++;
    if (outs !== LOADUSE) begin errors++; $display("FAIL load_use_over_jump: got %b want %b", outs, LOADUSE); end
    nextCycle();
  endtask

  task automatic test_branch_priority();
    setIn(5, 0, 1, 5, 1, 1, 0, 0, 0);
    #4;
    checks++;
    if (outs !== BRANCH) begin errors++; $display("FAIL branch_over_load_use: got %b want %b", outs, BRANCH); end
    nextCycle();
    setIn(5, 0, 1, 5, 1, 1, 1, 1, 1);
    #4;
    checks++;
    if (outs !== FREEZE) begin errors++; $display("FAIL freeze_over_all: got %b want %b", outs, FREEZE); end
    nextCycle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
  endtask

  task automatic test_irq_held();
    int acks = 0;
    logic [6:0] exp;
    for (int c = 0; c < 10; c++) begin
      setIn(c[4:0], 5'd1, 1'b0, 5'd2, c[0], c[1], 1'b0, 1'b1, 1'b1);
      #4;
      if (c <= 2) exp = FLUSH2;
      else if (c == 3) exp = VEC;
      else if (c[0]) exp = BRANCH;
      else if (c[1]) exp = JUMP;
      else exp = IDLE;
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL irq_held cycle %0d: got %b want %b", c, outs, exp); end
      if (irq_ack === 1'b1) acks++;
      nextCycle();
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL irq_single_ack: got %0d want 1", acks); end
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
  endtask

  task automatic test_drain_freeze();
    logic [6:0] expSeq [8];
    expSeq = '{FLUSH2, FLUSH2, FREEZE, FREEZE, FREEZE, FLUSH2, VEC, IDLE};
    for (int c = 0; c < 8; c++) begin
      // irq drops after entry: the sequence still completes.
      setIn(5, 0, 1, 5, 1, 0, (c >= 2 && c <= 4), (c == 0), 1);
      #4;
      if (c == 7) expSeq[7] = BRANCH;
      checks++;
      if (outs !== expSeq[c]) begin errors++; $display("FAIL drain_freeze cycle %0d: got %b want %b", c, outs, expSeq[c]); end
      nextCycle();
    end
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
  endtask

  task automatic test_reset_in_drain();
    int acks = 0;
    setIn(0, 0, 0, 0, 0, 0, 0, 1, 1);
    nextCycle();
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    reset = 1'b0;
    #2;
    checks++;
    if (outs !== IDLE) begin errors++; $display("FAIL reset_mid_drain: got %b want %b", outs, IDLE); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
`ifdef HAZARD_PERF_EN
    #1;
    checks++;
    if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_drain_stall_cnt: got %0d want 0", stall_cnt); end
`endif
    for (int c = 0; c < 5; c++) begin
      nextCycle();
      #4;
      if (irq_ack === 1'b1) acks++;
    end
    checks++;
    if (acks != 0) begin errors++; $display("FAIL reset_drain_no_ack: got %0d want 0", acks); end
    nextCycle();
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    doReset();
    for (int c = 0; c < 7; c++) begin
      setIn(4, 0, (c < 4), 4, 0, 0, (c >= 4), 0, 0);
      nextCycle();
    end
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #4;
    checks++;
    if (stall_cnt !== 16'd7) begin errors++; $display("FAIL perf_count: got %0d want 7", stall_cnt); end
    setIn(0, 0, 0, 0, 0, 0, 1, 0, 0);
    repeat (65530) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_saturate: got %h want ffff", stall_cnt); end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_hold: got %h want ffff", stall_cnt); end
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
  endtask
`endif

  // Reference model: seqPos counts unfrozen cycles of an interrupt sequence
  // (1..2 flushing, 3 vectoring, 0 not in a sequence).
  task automatic test_random();
    int seqPos = 0;
    bit mArmed = 1'b1;
    int mStall = 0;
    bit entry, lu;
    logic [6:0] exp;
    doReset();
    for (int n = 0; n < 3000; n++) begin
      setIn($urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 1) == 1),
            $urandom_range(0, 3), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0));
      #4;
      lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || ex_rt == id_rt);
      entry = 1'b0;
      if (mem_busy) exp = FREEZE;
      else if (seqPos == 1 || seqPos == 2) exp = FLUSH2;
      else if (seqPos == 3) exp = VEC;
      else if (irq && irq_en && mArmed) begin exp = FLUSH2; entry = 1'b1; end
      else if (ex_branch_taken) exp = BRANCH;
      else if (lu) exp = LOADUSE;
      else if (id_jump) exp = JUMP;
      else exp = IDLE;
      checks++;
      if (outs !== exp) begin errors++; $display("FAIL random step %0d: got %b want %b", n, outs, exp); end
`ifdef HAZARD_PERF_EN
      checks++;
      if (stall_cnt !== mStall[15:0]) begin errors++; $display("FAIL random_stall step %0d: got %0d want %0d", n, stall_cnt, mStall); end
`endif
      if (!exp[6] && mStall < 65535) mStall++;
      if (!mem_busy) begin
        if (seqPos == 3) begin seqPos = 0; mArmed = 1'b0; end
        else begin
          if (seqPos > 0) seqPos++;
          else if (entry) seqPos = 1;
          if (!irq) mArmed = 1'b1;
        end
      end
      nextCycle();
    end
  endtask

  initial begin
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_load_use();
    test_branch_priority();
    test_irq_held();
    test_drain_freeze();
    test_reset_in_drain();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
